fork_join_sched: RTL and testbench



---
 rtl/fork_join_pkg.sv | 22 ++
 rtl/fj_pending_tracker.sv | 34 +++
 rtl/fork_join_sched.sv | 150 +++++++++++++++
 tb/tb_fork_join_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fork_join_pkg.sv
// Shared types and default sizing for the fork/join job controller.
package fork_join_pkg;

  localparam int N_JOBS_DEF = 3;
  localparam int CW_DEF     = 16;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    JOIN   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/fj_pending_tracker.sv
// Outstanding-job bookkeeping: loads the fork mask, retires done pulses,
// adds the continuation job and flags done pulses for jobs that are not running.
module fj_pending_tracker #(
  parameter int N_JOBS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              retire_en,
  input  logic [N_JOBS-1:0] mask,
  input  logic [N_JOBS-1:0] job_done,
  input  logic [N_JOBS-1:0] set_vec,
  output logic [N_JOBS-1:0] pending,
  output logic [N_JOBS-1:0] retired,
  output logic              stray_err
);

  logic [N_JOBS-1:0] pending_q;

  assign pending   = pending_q;
  assign retired   = pending_q & ~job_done;
  assign stray_err = retire_en & (|(job_done & ~pending_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else if (load) begin
      pending_q <= mask;
    end else if (retire_en) begin
      pending_q <= retired | set_vec;
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join controller: forks a job set on go, signals the join condition,
// optionally launches one continuation job and reports when everything retires.
module fork_join_sched
  import fork_join_pkg::*;
#(
  parameter int N_JOBS = N_JOBS_DEF,
  parameter int CW     = CW_DEF,
  localparam int IW    = (N_JOBS > 1) ? $clog2(N_JOBS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [N_JOBS-1:0] launch_mask,
  input  logic [1:0]        join_mode,
  input  logic              cont_en,
  input  logic [IW-1:0]     cont_id,
  input  logic [N_JOBS-1:0] job_done,
  output logic [N_JOBS-1:0] job_start,
  output logic              busy,
  output logic              join_fire,
  output logic              all_done,
  output logic [CW-1:0]     join_cycles,
  output logic              proto_err,
  output logic [2:0]        state_dbg
);

  localparam logic [IW:0] ID_LIMIT = (IW + 1)'(N_JOBS);

  state_e            state_q, state_d;
  logic [N_JOBS-1:0] mask_q;
  logic [1:0]        mode_q;
  logic              cont_en_q;
  logic [IW-1:0]     cont_id_q;

  logic [N_JOBS-1:0] pending, retired, set_vec, cont_onehot;
  logic              load, retire_en, stray_err, cont_bad, join_cond, err_hit;

  assign state_dbg = state_q;

  fj_pending_tracker #(.N_JOBS(N_JOBS)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .retire_en (retire_en),
    .mask      (mask_q),
    .job_done  (job_done),
    .set_vec   (set_vec),
    .pending   (pending),
    .retired   (retired),
    .stray_err (stray_err)
  );

  // An out-of-range continuation id decodes to an all-zero one-hot.
  always_comb begin
    cont_onehot = '0;
    for (int i = 0; i < N_JOBS; i++) begin
      cont_onehot[i] = (cont_id_q == IW'(i));
    end
  end

  assign cont_bad = cont_en_q && (({1'b0, cont_id_q} >= ID_LIMIT) || (|(retired & cont_onehot)));

  always_comb begin
    if (mode_q == JOIN_ANY) begin
      join_cond = (|(job_done & pending)) || (mask_q == '0);
    end else if (mode_q == JOIN_NONE) begin
      join_cond = 1'b1;
    end else begin
      join_cond = (retired == '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    job_start = '0;
    busy      = 1'b0;
    join_fire = 1'b0;
    all_done  = 1'b0;
    load      = 1'b0;
    retire_en = 1'b0;
    set_vec   = '0;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = LAUNCH;
      end
      LAUNCH: begin
        job_start = mask_q;
        busy      = 1'b1;
        load      = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        retire_en = 1'b1;
        if (join_cond) state_d = JOIN;
      end
      JOIN: begin
        busy      = 1'b1;
        join_fire = 1'b1;
        retire_en = 1'b1;
        if (cont_en_q && !cont_bad) begin
          set_vec   = cont_onehot;
          job_start = cont_onehot;
        end
        state_d = ((retired | set_vec) != '0) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy      = 1'b1;
        retire_en = 1'b1;
        if (retired == '0) state_d = DONE;
      end
      DONE: begin
        all_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_hit = ((state_q == LAUNCH) && (|job_done)) || stray_err ||
                   ((state_q == JOIN) && cont_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      mode_q      <= 2'd0;
      cont_en_q   <= 1'b0;
      cont_id_q   <= '0;
      join_cycles <= '0;
      proto_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && go) begin
        mask_q    <= launch_mask;
        mode_q    <= join_mode;
        cont_en_q <= cont_en;
        cont_id_q <= cont_id;
      end
      // Counts WAIT cycles plus the JOIN cycle, sticking at all-ones.
      if (state_q == LAUNCH) begin
        join_cycles <= '0;
      end else if ((state_q == WAIT || state_q == JOIN) && join_cycles != '1) begin
        join_cycles <= join_cycles + CW'(1);
      end
      if (err_hit) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fork_join_sched.sv
// Directed bench for fork_join_sched with behavioural job engines of fixed latency.
module tb_fork_join_sched;

  localparam int N  = 3;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [N-1:0] launch_mask;
  logic [1:0]   join_mode;
  logic         cont_en;
  logic [1:0]   cont_id;
  logic [N-1:0] job_done;

  logic [N-1:0]  job_start, job_start_4;
  logic          busy, join_fire, all_done, proto_err;
  logic          busy_4, join_fire_4, all_done_4, proto_err_4;
  logic [CW-1:0] join_cycles;
  logic [3:0]    join_cycles_4;
  logic [2:0]    state_dbg, state_dbg_4;

  fork_join_sched #(.N_JOBS(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .go(go), .launch_mask(launch_mask), .join_mode(join_mode),
    .cont_en(cont_en), .cont_id(cont_id), .job_done(job_done), .job_start(job_start),
    .busy(busy), .join_fire(join_fire), .all_done(all_done), .join_cycles(join_cycles),
    .proto_err(proto_err), .state_dbg(state_dbg)
  );

  // Narrow-counter instance driven in lockstep, used for saturation.
  fork_join_sched #(.N_JOBS(N), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .go(go), .launch_mask(launch_mask), .join_mode(join_mode),
    .cont_en(cont_en), .cont_id(cont_id), .job_done(job_done), .job_start(job_start_4),
    .busy(busy_4), .join_fire(join_fire_4), .all_done(all_done_4), .join_cycles(join_cycles_4),
    .proto_err(proto_err_4), .state_dbg(state_dbg_4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int lat[N] = '{20, 10, 30};
  int due[N];
  int cyc;
  int jf_cyc, ad_cyc, busy_low_cyc, pe_cyc, jf_cnt;
  int start_cyc[N];
  int start_cnt[N];
  logic [CW-1:0] jc_hist[64];
  logic [3:0]    jc4_hist[64];

  task automatic do_reset();
    rst = 1'b1; go = 1'b0; job_done = '0;
    launch_mask = '0; join_mode = 2'd0; cont_en = 1'b0; cont_id = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic begin_scn(input logic [N-1:0] m, input logic [1:0] jm, input logic ce,
                           input logic [1:0] cid);
    do_reset();
    launch_mask = m; join_mode = jm; cont_en = ce; cont_id = cid;
    cyc = 0; jf_cyc = -1; ad_cyc = -1; busy_low_cyc = -1; pe_cyc = -1; jf_cnt = 0;
    for (int i = 0; i < N; i++) begin
      due[i] = -1; start_cyc[i] = -1; start_cnt[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, run the job models, record observed events.
  task automatic step(input logic go_v, input logic rst_v, input logic [N-1:0] extra);
    go  = go_v;
    rst = rst_v;
    for (int i = 0; i < N; i++) job_done[i] = (due[i] == cyc) | extra[i];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (job_start[i]) begin
        if (start_cyc[i] < 0) start_cyc[i] = cyc;
        start_cnt[i]++;
        due[i] = cyc + lat[i];
      end
    end
    if (join_fire) begin
      if (jf_cyc < 0) jf_cyc = cyc;
      jf_cnt++;
    end
    if (all_done && ad_cyc < 0) ad_cyc = cyc;
    if (!busy && cyc >= 1 && busy_low_cyc < 0) busy_low_cyc = cyc;
    if (proto_err && pe_cyc < 0) pe_cyc = cyc;
    if (cyc < 64) begin
      jc_hist[cyc]  = join_cycles;
      jc4_hist[cyc] = join_cycles_4;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({job_start, busy, join_fire, all_done, proto_err} !== '0) begin errors++; $display("FAIL reset_outputs got %b exp 0", {job_start, busy, join_fire, all_done, proto_err}); end
    checks++; if (join_cycles !== '0) begin errors++; $display("FAIL reset_join_cycles got %0d exp 0", join_cycles); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_join_any();
    begin_scn(3'b011, 2'd1, 1'b1, 2'd2);
    while (cyc <= 45) step(cyc == 0 || cyc == 43, 1'b0, '0);
    checks++; if (start_cyc[0] !== 1) begin errors++; $display("FAIL any_start0 got %0d exp 1", start_cyc[0]); end
    checks++; if (start_cyc[1] !== 1) begin errors++; $display("FAIL any_start1 got %0d exp 1", start_cyc[1]); end
    checks++; if (jf_cyc !== 12) begin errors++; $display("FAIL any_join_fire got %0d exp 12", jf_cyc); end
    checks++; if (start_cyc[2] !== 12) begin errors++; $display("FAIL any_cont_start got %0d exp 12", start_cyc[2]); end
    checks++; if (join_cycles !== 16'd11) begin errors++; $display("FAIL any_join_cycles got %0d exp 11", join_cycles); end
    checks++; if (ad_cyc !== 43) begin errors++; $display("FAIL any_all_done got %0d exp 43", ad_cyc); end
    checks++; if (busy_low_cyc !== 43) begin errors++; $display("FAIL any_busy_low got %0d exp 43", busy_low_cyc); end
    checks++; if (start_cnt[0] !== 1) begin errors++; $display("FAIL any_go_in_done got %0d exp 1", start_cnt[0]); end
    checks++; if (jf_cnt !== 1) begin errors++; $display("FAIL any_join_pulses got %0d exp 1", jf_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL any_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_join_all();
    begin_scn(3'b011, 2'd0, 1'b1, 2'd2);
    while (cyc <= 55) step(cyc == 0, 1'b0, '0);
    checks++; if (jf_cyc !== 22) begin errors++; $display("FAIL all_join_fire got %0d exp 22", jf_cyc); end
    checks++; if (start_cyc[2] !== 22) begin errors++; $display("FAIL all_cont_start got %0d exp 22", start_cyc[2]); end
    checks++; if (join_cycles !== 16'd21) begin errors++; $display("FAIL all_join_cycles got %0d exp 21", join_cycles); end
    checks++; if (ad_cyc !== 53) begin errors++; $display("FAIL all_all_done got %0d exp 53", ad_cyc); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL all_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_join_none();
    begin_scn(3'b111, 2'd2, 1'b0, 2'd0);
    while (cyc <= 35) step(cyc == 0, 1'b0, '0);
    checks++; if (jf_cyc !== 3) begin errors++; $display("FAIL none_join_fire got %0d exp 3", jf_cyc); end
    checks++; if (join_cycles !== 16'd2) begin errors++; $display("FAIL none_join_cycles got %0d exp 2", join_cycles); end
    checks++; if (ad_cyc !== 32) begin errors++; $display("FAIL none_all_done got %0d exp 32", ad_cyc); end
    checks++; if (start_cnt[2] !== 1) begin errors++; $display("FAIL none_start2_count got %0d exp 1", start_cnt[2]); end
  endtask

  task automatic test_spurious_done();
    begin_scn(3'b011, 2'd0, 1'b0, 2'd0);
    while (cyc <= 25) step(cyc == 0, 1'b0, (cyc == 5) ? 3'b100 : 3'b000);
    checks++; if (pe_cyc !== 6) begin errors++; $display("FAIL spur_err_cycle got %0d exp 6", pe_cyc); end
    checks++; if (jf_cyc !== 22) begin errors++; $display("FAIL spur_join_fire got %0d exp 22", jf_cyc); end
    checks++; if (ad_cyc !== 23) begin errors++; $display("FAIL spur_all_done got %0d exp 23", ad_cyc); end
  endtask

  task automatic test_cont_pending();
    begin_scn(3'b011, 2'd1, 1'b1, 2'd0);
    while (cyc <= 25) step(cyc == 0, 1'b0, '0);
    checks++; if (pe_cyc !== 13) begin errors++; $display("FAIL contp_err_cycle got %0d exp 13", pe_cyc); end
    checks++; if (start_cnt[0] !== 1) begin errors++; $display("FAIL contp_no_restart got %0d exp 1", start_cnt[0]); end
    checks++; if (ad_cyc !== 22) begin errors++; $display("FAIL contp_all_done got %0d exp 22", ad_cyc); end
  endtask

  task automatic test_empty_mask();
    begin_scn(3'b000, 2'd1, 1'b0, 2'd0);
    while (cyc <= 8) step(cyc == 0, 1'b0, '0);
    checks++; if (jf_cyc !== 3) begin errors++; $display("FAIL empty_join_fire got %0d exp 3", jf_cyc); end
    checks++; if (ad_cyc !== 4) begin errors++; $display("FAIL empty_all_done got %0d exp 4", ad_cyc); end
    checks++; if (start_cnt[0] + start_cnt[1] + start_cnt[2] !== 0) begin errors++; $display("FAIL empty_starts got %0d exp 0", start_cnt[0] + start_cnt[1] + start_cnt[2]); end
  endtask

  task automatic test_reset_mid();
    begin_scn(3'b011, 2'd1, 1'b1, 2'd2);
    while (cyc <= 25) begin
      step(cyc == 0 || cyc == 5, cyc == 15, '0);
      if (cyc == 16) begin
        checks++; if ({job_start, busy, join_fire, all_done, proto_err} !== '0) begin errors++; $display("FAIL rmid_outputs got %b exp 0", {job_start, busy, join_fire, all_done, proto_err}); end
        checks++; if (join_cycles !== '0) begin errors++; $display("FAIL rmid_join_cycles got %0d exp 0", join_cycles); end
      end
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_late_done got %b exp 0", proto_err); end
    checks++; if (start_cnt[0] !== 1) begin errors++; $display("FAIL rmid_go_busy got %0d exp 1", start_cnt[0]); end
    checks++; if (ad_cyc !== -1) begin errors++; $display("FAIL rmid_no_all_done got %0d exp -1", ad_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
  endtask

  task automatic test_saturate();
    lat[0] = 40;
    begin_scn(3'b001, 2'd0, 1'b0, 2'd0);
    while (cyc <= 46) step(cyc == 0, 1'b0, '0);
    lat[0] = 20;
    checks++; if (jc4_hist[14] !== 4'd12) begin errors++; $display("FAIL sat_mid got %0d exp 12", jc4_hist[14]); end
    checks++; if (jc4_hist[20] !== 4'd15) begin errors++; $display("FAIL sat_clamp got %0d exp 15", jc4_hist[20]); end
    checks++; if (join_cycles_4 !== 4'd15) begin errors++; $display("FAIL sat_final got %0d exp 15", join_cycles_4); end
    checks++; if (join_cycles !== 16'd41) begin errors++; $display("FAIL wide_final got %0d exp 41", join_cycles); end
    checks++; if (ad_cyc !== 43) begin errors++; $display("FAIL sat_all_done got %0d exp 43", ad_cyc); end
  endtask

  initial begin
    test_reset();
    test_join_any();
    test_join_all();
    test_join_none();
    test_spurious_done();
    test_cont_pending();
    test_empty_mask();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
